// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ext
//  Purpose  : Parametrised UART receiver. Configurable data width, parity
//             and stop bits, 3-sample majority voting, false-start
//             rejection, framing/parity flags, overrun pulse and a held
//             valid/ready character output.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_ext #(
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  input  logic                 rx_data_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;

  localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] CNT_S0   = 16'(HALF - 1);
  localparam logic [15:0] CNT_S1   = 16'(HALF);
  localparam logic [15:0] CNT_DEC  = 16'(HALF + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  generate
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_rx_ext: DATA_BITS must be in 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_rx_ext: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end
    if ((CYCLE < 8) || (CYCLE > 65536)) begin : g_bad_cycle
      $error("uart_rx_ext: CYCLE must be 8..65536 clocks per bit");
    end
  endgenerate

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  logic [15:0]          cnt;
  logic                 bit_end;
  logic                 decide;
  logic                 samp0;
  logic                 samp1;
  logic                 maj;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 last_data;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_expected;
  logic                 fe_pending;
  logic                 pe_pending;
  logic                 complete;

  assign fall         = rx_prev & ~rx_sync;
  assign bit_end      = (cnt == CNT_LAST);
  assign decide       = (cnt == CNT_DEC);
  assign maj          = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
  assign last_data    = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop    = (STOP_BITS == 1) || stop_idx;
  assign par_expected = (PARITY == 1) ? ~(^shreg) : (^shreg);

  // Two-flop synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; completion leaves STOP at the final decision point
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START: begin
        if (decide && maj) state_nxt = S_IDLE;
        else if (bit_end)  state_nxt = S_DATA;
      end
      S_DATA:   if (bit_end && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (decide && last_stop) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and character-complete strobe
  always_comb begin
    rx_busy  = (state != S_IDLE);
    complete = (state == S_STOP) && decide && last_stop;
  end

  // Bit-period counter, held at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == S_IDLE) || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Early mid-bit samples and data/stop bit indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0    <= 1'b0;
      samp1    <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (cnt == CNT_S0) samp0 <= rx_sync;
      if (cnt == CNT_S1) samp1 <= rx_sync;
      if (state != S_DATA)  bit_idx <= '0;
      else if (bit_end)     bit_idx <= bit_idx + 4'd1;
      if (state != S_STOP)  stop_idx <= 1'b0;
      else if (bit_end)     stop_idx <= 1'b1;
    end
  end

  // Character assembly and pending error flags for the frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      fe_pending <= 1'b0;
      pe_pending <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        fe_pending <= 1'b0;
        pe_pending <= 1'b0;
      end
      if ((state == S_DATA) && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if ((state == S_PARITY) && decide && (maj != par_expected)) pe_pending <= 1'b1;
      if ((state == S_STOP) && decide && !maj) fe_pending <= 1'b1;
    end
  end

  // Held output character with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      parity_err    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (rx_data_valid && !rx_data_ready) begin
          // Consumer still holds the previous character: drop the new one
          overrun <= 1'b1;
        end else begin
          rx_data       <= shreg;
          frame_err     <= fe_pending | ~maj;
          parity_err    <= pe_pending;
          rx_data_valid <= 1'b1;
        end
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
        frame_err     <= 1'b0;
        parity_err    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ext
//  Purpose  : Self-checking bench for uart_rx_ext. Four receivers at 10
//             clocks per bit: 8N1, 8E1, 8O1 and 7N2. Line frames are built
//             from the character rules and compared to a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ext;

  localparam int CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rx;
  logic [3:0] rdy;
  logic [3:0] v, fe, pe, ov, busy;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;

  int tests = 0;
  int fails = 0;
  int ndb [4];
  int par [4];
  int nst [4];
  int ovc [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_FRE(10), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx[0]), .rx_data_ready(rdy[0]), .rx_data(d0),
    .rx_data_valid(v[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .rx_busy(busy[0]));
  uart_rx_ext #(.CLK_FRE(10), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx[1]), .rx_data_ready(rdy[1]), .rx_data(d1),
    .rx_data_valid(v[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .rx_busy(busy[1]));
  uart_rx_ext #(.CLK_FRE(10), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx[2]), .rx_data_ready(rdy[2]), .rx_data(d2),
    .rx_data_valid(v[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]), .rx_busy(busy[2]));
  uart_rx_ext #(.CLK_FRE(10), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx[3]), .rx_data_ready(rdy[3]), .rx_data(d3),
    .rx_data_valid(v[3]), .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]), .rx_busy(busy[3]));

  // Count overrun pulse cycles per receiver
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (ov[i]) ovc[i] <= ovc[i] + 1;
  end

  function automatic logic [8:0] dat(input int idx);
    case (idx)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {1'b0, d2};
      default: return {2'b00, d3};
    endcase
  endfunction

  // Parity bit a correct transmitter puts on the line: odd/even total ones
  function automatic logic rule_par(input int idx, input logic [8:0] d);
    int ones = 0;
    for (int i = 0; i < ndb[idx]; i++) ones += int'(d[i]);
    if (par[idx] == 2) return logic'(ones % 2);
    return logic'((ones % 2) == 0);
  endfunction

  function automatic logic [8:0] mask(input int idx);
    logic [8:0] m = '0;
    for (int i = 0; i < ndb[idx]; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drive one frame, each bit CYC clocks; called right after a falling clock edge
  task automatic send(input int idx, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
    rx[idx] = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < ndb[idx]; i++) begin
      rx[idx] = d[i];
      repeat (CYC) @(negedge clk);
    end
    if (par[idx] != 0) begin
      rx[idx] = pbit;
      repeat (CYC) @(negedge clk);
    end
    for (int s = 0; s < nst[idx]; s++) begin
      rx[idx] = stops[s];
      repeat (CYC) @(negedge clk);
    end
    rx[idx] = 1'b1;
  endtask

  task automatic wait_valid(input int idx, input int limit, output logic got,
                            output logic [8:0] d, output logic f, output logic p);
    got = 1'b0; d = '0; f = 1'b0; p = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (v[idx]) begin
        got = 1'b1; d = dat(idx); f = fe[idx]; p = pe[idx];
      end
    end
  endtask

  task automatic xfer(input int idx, input logic [8:0] d, input logic pbit, input logic [1:0] stops,
                      output logic got, output logic [8:0] od, output logic of, output logic op);
    logic g, f, p;
    logic [8:0] x;
    fork
      send(idx, d, pbit, stops);
      wait_valid(idx, 160, g, x, f, p);
    join
    got = g; od = x; of = f; op = p;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 4'hF; rdy = 4'hF;
    repeat (3) @(negedge clk);
    tests++;
    if ({v, busy, ov, fe, pe} !== 20'h0) begin
      fails++; $display("FAIL reset_flags: got %h required 0", {v, busy, ov, fe, pe});
    end
    tests++;
    if ({d0, d1, d2, d3} !== 31'h0) begin
      fails++; $display("FAIL reset_data: got %h required 0", {d0, d1, d2, d3});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    logic g, f, p; logic [8:0] x;
    logic [8:0] pat [2];
    pat[0] = 9'h055; pat[1] = 9'h0A3;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      xfer(0, pat[i], 1'b0, 2'b11, g, x, f, p);
      tests++;
      if ({g, x, f, p} !== {1'b1, pat[i], 2'b00}) begin
        fails++; $display("FAIL basic_%0d: got v=%b d=%h fe=%b pe=%b required v=1 d=%h fe=0 pe=0", i, g, x, f, p, pat[i]);
      end
    end
  endtask

  task automatic test_parity;
    logic g, f, p, ep; logic [8:0] x;
    @(negedge clk);
    for (int idx = 1; idx <= 2; idx++) begin
      for (int b = 1; b >= 0; b--) begin
        ep = (logic'(b) !== rule_par(idx, 9'h007));
        xfer(idx, 9'h007, logic'(b), 2'b11, g, x, f, p);
        tests++;
        if ({g, x, f, p} !== {1'b1, 9'h007, 1'b0, ep}) begin
          fails++; $display("FAIL parity_u%0d_bit%0d: got v=%b d=%h fe=%b pe=%b required v=1 d=007 fe=0 pe=%b", idx, b, g, x, f, p, ep);
        end
      end
    end
  endtask

  task automatic test_stop2;
    logic g, f, p; logic [8:0] x;
    @(negedge clk);
    xfer(3, 9'h041, 1'b0, 2'b01, g, x, f, p);
    tests++;
    if ({g, x, f, p} !== {1'b1, 9'h041, 2'b10}) begin
      fails++; $display("FAIL stop2_low: got v=%b d=%h fe=%b pe=%b required v=1 d=041 fe=1 pe=0", g, x, f, p);
    end
    repeat (5) @(negedge clk);
    xfer(3, 9'h041, 1'b0, 2'b11, g, x, f, p);
    tests++;
    if ({g, x, f, p} !== {1'b1, 9'h041, 2'b00}) begin
      fails++; $display("FAIL stop2_good: got v=%b d=%h fe=%b pe=%b required v=1 d=041 fe=0 pe=0", g, x, f, p);
    end
  endtask

  task automatic test_glitch;
    int nv = 0;
    logic seen_busy = 1'b0;
    logic late_busy = 1'b1;
    @(negedge clk);
    rx[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) rx[0] = 1'b1;
      if (busy[0]) seen_busy = 1'b1;
      if (k == 13) late_busy = busy[0];
      if (v[0]) nv++;
    end
    tests++;
    if ({seen_busy, late_busy} !== 2'b10) begin
      fails++; $display("FAIL glitch_busy: got seen=%b at_13=%b required seen=1 at_13=0", seen_busy, late_busy);
    end
    tests++;
    if (nv !== 0) begin
      fails++; $display("FAIL glitch_valid: got %0d valid cycles required 0", nv);
    end
  endtask

  task automatic test_spike;
    logic g, f, p; logic [8:0] x;
    @(negedge clk);
    fork
      send(0, 9'h000, 1'b0, 2'b11);
      begin
        repeat (15) @(negedge clk);
        rx[0] = 1'b1;
        @(negedge clk);
        rx[0] = 1'b0;
      end
      wait_valid(0, 160, g, x, f, p);
    join
    tests++;
    if ({g, x, f, p} !== {1'b1, 9'h000, 2'b00}) begin
      fails++; $display("FAIL spike: got v=%b d=%h fe=%b pe=%b required v=1 d=000 fe=0 pe=0", g, x, f, p);
    end
  endtask

  task automatic test_overrun;
    logic g, f, p; logic [8:0] x;
    int ob;
    @(negedge clk);
    rdy[0] = 1'b0;
    xfer(0, 9'h011, 1'b0, 2'b11, g, x, f, p);
    tests++;
    if ({g, x} !== {1'b1, 9'h011}) begin
      fails++; $display("FAIL overrun_first: got v=%b d=%h required v=1 d=011", g, x);
    end
    ob = ovc[0];
    send(0, 9'h022, 1'b0, 2'b11);
    repeat (5) @(negedge clk);
    tests++;
    if (ovc[0] - ob !== 1) begin
      fails++; $display("FAIL overrun_pulse: got %0d cycles required 1", ovc[0] - ob);
    end
    tests++;
    if ({v[0], d0, fe[0], pe[0]} !== {1'b1, 8'h11, 2'b00}) begin
      fails++; $display("FAIL overrun_hold: got v=%b d=%h fe=%b pe=%b required v=1 d=11 fe=0 pe=0", v[0], d0, fe[0], pe[0]);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (v[0] !== 1'b0) begin
      fails++; $display("FAIL overrun_accept: got v=%b required 0", v[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic g, f, p, sv; logic [8:0] x; logic [7:0] sd;
    int ob;
    @(negedge clk);
    rdy[0] = 1'b0;
    xfer(0, 9'h0A5, 1'b0, 2'b11, g, x, f, p);
    ob = ovc[0];
    sv = 1'b0; sd = '0;
    fork
      send(0, 9'h05A, 1'b0, 2'b11);
      begin
        // Ready goes high for the cycle whose edge loads the second character
        repeat (99) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        sv = v[0]; sd = d0;
      end
    join
    tests++;
    if ({g, x, sv, sd} !== {1'b1, 9'h0A5, 1'b1, 8'h5A}) begin
      fails++; $display("FAIL same_cycle_load: got first=%b/%h after v=%b d=%h required 1/0a5 v=1 d=5a", g, x, sv, sd);
    end
    tests++;
    if (ovc[0] !== ob) begin
      fails++; $display("FAIL same_cycle_overrun: got %0d pulses required 0", ovc[0] - ob);
    end
    @(negedge clk);
    tests++;
    if (v[0] !== 1'b0) begin
      fails++; $display("FAIL same_cycle_drain: got v=%b required 0", v[0]);
    end
  endtask

  task automatic test_break;
    int nv = 0;
    logic [8:0] x = '1;
    logic f = 1'b0, p = 1'b1;
    @(negedge clk);
    rx[0] = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (k == 120) rx[0] = 1'b1;
      if (v[0]) begin nv++; x = dat(0); f = fe[0]; p = pe[0]; end
    end
    tests++;
    if ({nv, x, f, p} !== {32'd1, 9'h000, 2'b10}) begin
      fails++; $display("FAIL break: got %0d chars d=%h fe=%b pe=%b required 1 char d=000 fe=1 pe=0", nv, x, f, p);
    end
  endtask

  task automatic test_random;
    logic g, f, p, pbit, ef, ep; logic [8:0] x, d; logic [1:0] st;
    @(negedge clk);
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 5; n++) begin
        d    = 9'($urandom) & mask(idx);
        pbit = rule_par(idx, d) ^ ($urandom_range(0, 3) == 0);
        st   = 2'b11;
        for (int s = 0; s < nst[idx]; s++) st[s] = ($urandom_range(0, 3) != 0);
        ef = 1'b0;
        for (int s = 0; s < nst[idx]; s++) if (!st[s]) ef = 1'b1;
        ep = (par[idx] != 0) && (pbit != rule_par(idx, d));
        xfer(idx, d, pbit, st, g, x, f, p);
        tests++;
        if ({g, x, f, p} !== {1'b1, d, ef, ep}) begin
          fails++; $display("FAIL random_u%0d_%0d: got v=%b d=%h fe=%b pe=%b required v=1 d=%h fe=%b pe=%b", idx, n, g, x, f, p, d, ef, ep);
        end
        repeat ($urandom_range(3, 15)) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic g, f, p; logic [8:0] x;
    logic [7:0] c = 8'h3C;
    @(negedge clk);
    rdy[0] = 1'b0;
    xfer(0, 9'h099, 1'b0, 2'b11, g, x, f, p);
    rx[0] = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx[0] = c[i];
      repeat (CYC) @(negedge clk);
    end
    rx[0] = c[4];
    repeat (CYC / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({v[0], busy[0], fe[0], pe[0], ov[0], d0} !== 13'h0) begin
      fails++; $display("FAIL midreset_clear: got v=%b busy=%b fe=%b pe=%b ov=%b d=%h required all 0", v[0], busy[0], fe[0], pe[0], ov[0], d0);
    end
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    repeat (5) @(negedge clk);
    xfer(0, 9'h03C, 1'b0, 2'b11, g, x, f, p);
    tests++;
    if ({g, x, f, p} !== {1'b1, 9'h03C, 2'b00}) begin
      fails++; $display("FAIL midreset_next: got v=%b d=%h fe=%b pe=%b required v=1 d=03c fe=0 pe=0", g, x, f, p);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    ndb[0] = 8; ndb[1] = 8; ndb[2] = 8; ndb[3] = 7;
    par[0] = 0; par[1] = 2; par[2] = 1; par[3] = 0;
    nst[0] = 1; nst[1] = 1; nst[2] = 1; nst[3] = 2;
    rx  = 4'hF;
    rdy = 4'hF;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_glitch();
    test_spike();
    test_overrun();
    test_back_to_back();
    test_break();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
